// File: rtl/neuron_accumulate_pkg.sv
// Shared constants for the neuron datapath: Q-format widths, FSM state codes
// and saturation limits, reused by the fetch and writeback blocks.
package neuron_accumulate_pkg;

  localparam int Q_DATA_W = 16;
  localparam int Q_FRAC   = 8;
  localparam int Q_ACC_W  = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_ACT   = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  localparam logic signed [Q_ACC_W-1:0]  ACC_SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [Q_ACC_W-1:0]  ACC_SAT_MIN = 32'sh8000_0000;
  localparam logic signed [Q_DATA_W-1:0] Q_SAT_MAX   = 16'sh7FFF;
  localparam logic signed [Q_DATA_W-1:0] Q_SAT_MIN   = 16'sh8000;

endpackage

// File: rtl/neuron_accumulate_if.sv
// Bundle of the neuron evaluator's command, fetch-stream and write-port signals.
interface neuron_accumulate_if #(
  parameter int DATA_W = 16
);
  logic                     start;
  logic [DATA_W-1:0]        num_adds;
  logic [DATA_W-1:0]        dest_addr;
  logic                     fetch_en;
  logic signed [DATA_W-1:0] in_val;
  logic signed [DATA_W-1:0] in_wt;
  logic                     in_we;
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     busy;
  logic                     done;

  modport slave (
    input  start, num_adds, dest_addr, in_val, in_wt, in_we,
    output fetch_en, wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output start, num_adds, dest_addr, in_val, in_wt, in_we,
    input  fetch_en, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/neuron_accumulate_fx_mac.sv
// Fixed-point multiply-accumulate: Q-format product shifted back by FRAC
// (floor), then added into a saturating ACC_W accumulator.
module fx_mac
  import neuron_accumulate_pkg::*;
#(
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC   = Q_FRAC,
  parameter int ACC_W  = Q_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_val,
  input  logic signed [DATA_W-1:0] i_wt,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_term;
  logic signed [ACC_W-1:0]  r_acc;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [PROD_W-1:0] term
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(term);
    if (s > SUM_W'(A_MAX))      sat_add = A_MAX;
    else if (s < SUM_W'(A_MIN)) sat_add = A_MIN;
    else                        sat_add = s[ACC_W-1:0];
  endfunction

  assign w_prod = i_val * i_wt;
  assign w_term = w_prod >>> FRAC;

  // Stage boundary: accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= sat_add(r_acc, w_term);
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/neuron_accumulate.sv
// One neuron evaluation: request num_adds terms from the fetch stage, accumulate
// the weighted sum, activate and write the result to neuron memory.
module neuron_accumulate
  import neuron_accumulate_pkg::*;
#(
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC   = Q_FRAC,
  parameter int ACC_W  = Q_ACC_W,
  parameter int RELU   = 1
) (
  input  logic               clk,
  input  logic               rst,
  neuron_accumulate_if.slave bus
);

  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_W-1:0]        r_num;
  logic [DATA_W-1:0]        r_dest;
  logic [DATA_W-1:0]        r_issued;
  logic [DATA_W-1:0]        r_rcvd;
  logic [DATA_W:0]          w_rcvd_nxt;
  logic                     w_acc_en;
  logic                     w_clr;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0]        r_wr_addr;

  function automatic logic signed [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] a);
    logic signed [DATA_W-1:0] r;
    if (a > ACC_W'(D_MAX))      r = D_MAX;
    else if (a < ACC_W'(D_MIN)) r = D_MIN;
    else                        r = a[DATA_W-1:0];
    if (RELU != 0 && r[DATA_W-1]) r = '0;
    activate = r;
  endfunction

  assign w_clr      = (r_state == S_IDLE) && bus.start;
  assign w_acc_en   = bus.in_we && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
  assign w_rcvd_nxt = {1'b0, r_rcvd} + {{DATA_W{1'b0}}, w_acc_en};

  fx_mac #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_acc_en),
    .i_val (bus.in_val),
    .i_wt  (bus.in_wt),
    .o_acc (w_acc)
  );

  // The term arriving on the DRAIN exit cycle is counted here, so ACT always sees it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.num_adds == '0) ? S_ACT : S_ISSUE;
      S_ISSUE: if (({1'b0, r_issued} + (DATA_W+1)'(1)) == {1'b0, r_num}) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rcvd_nxt >= {1'b0, r_num}) w_state_nxt = S_ACT;
      S_ACT:   w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage boundary: control, counters and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_dest    <= '0;
      r_issued  <= '0;
      r_rcvd    <= '0;
      r_wr_data <= '0;
      r_wr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_num    <= bus.num_adds;
        r_dest   <= bus.dest_addr;
        r_issued <= '0;
        r_rcvd   <= '0;
      end else begin
        if (r_state == S_ISSUE) r_issued <= r_issued + DATA_W'(1);
        if (w_acc_en)           r_rcvd   <= w_rcvd_nxt[DATA_W-1:0];
      end
      if (r_state == S_ACT) begin
        r_wr_data <= activate(w_acc);
        r_wr_addr <= r_dest;
      end
    end
  end

  assign bus.fetch_en = (r_state == S_ISSUE);
  assign bus.wr_en    = (r_state == S_WRITE);
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_neuron_accumulate.sv
// Bench for neuron_accumulate: a ReLU and a linear instance share one stimulus
// stream; a fetch-stage model feeds terms and a scoreboard holds expected writes.
module tb_neuron_accumulate;
  import neuron_accumulate_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data_r;
    logic [15:0] data_l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] tv_val [17];
  logic [15:0] tv_wt  [17];
  int          tv_gap [17];

  bit   model_on;
  int   pending, dlv_idx, wait_ctr, fe_count;
  logic r_fe, r_st;
  int   wr_count, wr_cyc, start_cyc;
  logic [15:0] wr_addr_s, wr_r_s, wr_l_s;
  exp_t sb_q [$];

  neuron_accumulate_if #(.DATA_W(16)) bus_r ();
  neuron_accumulate_if #(.DATA_W(16)) bus_l ();

  assign bus_l.start     = bus_r.start;
  assign bus_l.num_adds  = bus_r.num_adds;
  assign bus_l.dest_addr = bus_r.dest_addr;
  assign bus_l.in_val    = bus_r.in_val;
  assign bus_l.in_wt     = bus_r.in_wt;
  assign bus_l.in_we     = bus_r.in_we;

  neuron_accumulate #(.DATA_W(16), .FRAC(8), .ACC_W(32), .RELU(1)) u_relu (.clk(clk), .rst(rst), .bus(bus_r));
  neuron_accumulate #(.DATA_W(16), .FRAC(8), .ACC_W(32), .RELU(0)) u_lin  (.clk(clk), .rst(rst), .bus(bus_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fetch-stage model: each fetch_en queues one request, delivered after tv_gap idle cycles.
  always @(posedge clk) begin
    r_fe = bus_r.fetch_en;
    r_st = bus_r.start && !bus_r.busy && !rst;
    #1;
    if (rst) pending = 0;
    if (r_st) begin pending = 0; dlv_idx = 0; wait_ctr = tv_gap[0]; fe_count = 0; end
    if (r_fe) begin fe_count++; pending++; end
    if (model_on) begin
      if (pending > 0 && wait_ctr == 0 && dlv_idx < 17) begin
        bus_r.in_we  = 1'b1;
        bus_r.in_val = tv_val[dlv_idx];
        bus_r.in_wt  = tv_wt[dlv_idx];
        pending--;
        dlv_idx++;
        wait_ctr = (dlv_idx < 17) ? tv_gap[dlv_idx] : 0;
      end else begin
        bus_r.in_we  = 1'b0;
        bus_r.in_val = 16'($urandom);
        bus_r.in_wt  = 16'($urandom);
        if (pending > 0 && wait_ctr > 0) wait_ctr--;
      end
    end
  end

  always @(negedge clk) begin
    if (bus_r.wr_en) begin
      wr_count++;
      wr_cyc    = cyc;
      wr_addr_s = bus_r.wr_addr;
      wr_r_s    = bus_r.wr_data;
      wr_l_s    = bus_l.wr_data;
    end
  end

  function automatic exp_t model(input int n, input logic [15:0] dest);
    exp_t   e;
    longint acc, p, lin;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(tv_val[i])) * longint'($signed(tv_wt[i]));
      p = p >>> 8;
      acc = acc + p;
      if (acc > longint'(ACC_SAT_MAX)) acc = longint'(ACC_SAT_MAX);
      if (acc < longint'(ACC_SAT_MIN)) acc = longint'(ACC_SAT_MIN);
    end
    lin = acc;
    if (lin > longint'(Q_SAT_MAX)) lin = longint'(Q_SAT_MAX);
    if (lin < longint'(Q_SAT_MIN)) lin = longint'(Q_SAT_MIN);
    e.addr   = dest;
    e.data_l = lin[15:0];
    e.data_r = (lin < 0) ? 16'h0000 : lin[15:0];
    return e;
  endfunction

  task automatic launch(input int n, input logic [15:0] dest);
    sb_q.push_back(model(n, dest));
    @(posedge clk); #1;
    wr_count        = 0;
    bus_r.start     = 1'b1;
    bus_r.num_adds  = 16'(n);
    bus_r.dest_addr = dest;
    start_cyc       = cyc;
    @(posedge clk); #1;
    bus_r.start     = 1'b0;
    bus_r.num_adds  = 16'($urandom);
    bus_r.dest_addr = 16'($urandom);
  endtask

  task automatic await_done(output bit timed_out, output int done_cyc);
    timed_out = 1'b1;
    done_cyc  = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_r.done) begin timed_out = 1'b0; done_cyc = cyc; break; end
    end
  endtask

  task automatic fill(input int n, input int max_gap);
    for (int i = 0; i < 17; i++) begin
      tv_val[i] = 16'($urandom);
      tv_wt[i]  = 16'($urandom);
      tv_gap[i] = (i < n) ? $urandom_range(0, max_gap) : 0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus_r.busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus_r.busy); end
    vectors++; if (bus_r.fetch_en !== 1'b0) begin miscompares++; $display("FAIL rst_fetch_en: got %b want 0", bus_r.fetch_en); end
    vectors++; if (bus_r.wr_en !== 1'b0)    begin miscompares++; $display("FAIL rst_wr_en: got %b want 0", bus_r.wr_en); end
    vectors++; if (bus_r.done !== 1'b0)     begin miscompares++; $display("FAIL rst_done: got %b want 0", bus_r.done); end
    vectors++; if (bus_r.wr_addr !== 16'h0) begin miscompares++; $display("FAIL rst_wr_addr: got %h want 0000", bus_r.wr_addr); end
    vectors++; if (bus_r.wr_data !== 16'h0) begin miscompares++; $display("FAIL rst_wr_data: got %h want 0000", bus_r.wr_data); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus_r.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus_r.busy); end
  endtask

  task automatic test_basic();
    exp_t e; bit to; int dc;
    tv_val[0] = 16'h0100; tv_val[1] = 16'h0200; tv_val[2] = 16'hFF80;
    for (int i = 0; i < 17; i++) begin tv_gap[i] = 0; if (i < 3) tv_wt[i] = 16'h0100; end
    launch(3, 16'h0040);
    await_done(to, dc);
    e = sb_q.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout: done not seen within budget"); end
    vectors++; if (wr_r_s !== 16'h0280)    begin miscompares++; $display("FAIL basic_data_relu: got %h want 0280", wr_r_s); end
    vectors++; if (wr_l_s !== e.data_l)    begin miscompares++; $display("FAIL basic_data_lin: got %h want %h", wr_l_s, e.data_l); end
    vectors++; if (wr_addr_s !== 16'h0040) begin miscompares++; $display("FAIL basic_addr: got %h want 0040", wr_addr_s); end
    vectors++; if (wr_count !== 1)         begin miscompares++; $display("FAIL basic_wr_count: got %0d want 1", wr_count); end
    vectors++; if (fe_count !== 3)         begin miscompares++; $display("FAIL basic_fetch_cnt: got %0d want 3", fe_count); end
    vectors++; if (wr_cyc - start_cyc !== 6) begin miscompares++; $display("FAIL basic_latency: got %0d want 6", wr_cyc - start_cyc); end
    vectors++; if (dc !== wr_cyc + 1)      begin miscompares++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, wr_cyc + 1); end
    @(negedge clk);
    vectors++; if (bus_r.busy !== 1'b0)    begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", bus_r.busy); end
  endtask

  task automatic test_relu();
    exp_t e; bit to; int dc;
    fill(1, 0); tv_gap[0] = 0;
    tv_val[0] = 16'h0100; tv_wt[0] = 16'hFE00;
    launch(1, 16'h0010);
    await_done(to, dc);
    e = sb_q.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL relu_timeout: done not seen within budget"); end
    vectors++; if (wr_r_s !== 16'h0000) begin miscompares++; $display("FAIL relu_clamp: got %h want 0000", wr_r_s); end
    vectors++; if (wr_l_s !== 16'hFE00) begin miscompares++; $display("FAIL relu_off_pass: got %h want fe00", wr_l_s); end
    vectors++; if (wr_addr_s !== e.addr) begin miscompares++; $display("FAIL relu_addr: got %h want %h", wr_addr_s, e.addr); end
  endtask

  task automatic test_saturation();
    exp_t e; bit to; int dc;
    for (int pass = 0; pass < 2; pass++) begin
      fill(4, 0);
      for (int i = 0; i < 4; i++) begin tv_val[i] = (pass == 0) ? 16'h7FFF : 16'h8001; tv_wt[i] = 16'h7FFF; tv_gap[i] = 0; end
      launch(4, 16'h0100 + 16'(pass));
      await_done(to, dc);
      e = sb_q.pop_front();
      vectors++; if (to) begin miscompares++; $display("FAIL sat_timeout: pass %0d done not seen", pass); end
      vectors++; if (wr_l_s !== ((pass == 0) ? 16'h7FFF : 16'h8000)) begin miscompares++; $display("FAIL sat_lin: pass %0d got %h want %h", pass, wr_l_s, (pass == 0) ? 16'h7FFF : 16'h8000); end
      vectors++; if (wr_r_s !== ((pass == 0) ? 16'h7FFF : 16'h0000)) begin miscompares++; $display("FAIL sat_relu: pass %0d got %h want %h", pass, wr_r_s, (pass == 0) ? 16'h7FFF : 16'h0000); end
      vectors++; if (wr_addr_s !== e.addr) begin miscompares++; $display("FAIL sat_addr: got %h want %h", wr_addr_s, e.addr); end
    end
  endtask

  task automatic test_zero_terms();
    exp_t e; bit to; int dc;
    fill(0, 0);
    launch(0, 16'h0123);
    await_done(to, dc);
    e = sb_q.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL zero_timeout: done not seen within budget"); end
    vectors++; if (fe_count !== 0)           begin miscompares++; $display("FAIL zero_fetch_cnt: got %0d want 0", fe_count); end
    vectors++; if (wr_cyc - start_cyc !== 2) begin miscompares++; $display("FAIL zero_latency: got %0d want 2", wr_cyc - start_cyc); end
    vectors++; if (wr_l_s !== 16'h0000)      begin miscompares++; $display("FAIL zero_data: got %h want 0000", wr_l_s); end
    vectors++; if (wr_addr_s !== e.addr)     begin miscompares++; $display("FAIL zero_addr: got %h want %h", wr_addr_s, e.addr); end
    vectors++; if (dc !== wr_cyc + 1)        begin miscompares++; $display("FAIL zero_done_cycle: got %0d want %0d", dc, wr_cyc + 1); end
  endtask

  task automatic test_stall();
    exp_t e; bit to; int dc;
    fill(5, 5);
    tv_gap[1] = 5; tv_gap[3] = 0;
    launch(5, 16'h0200);
    repeat (2) @(posedge clk);
    #1; bus_r.start = 1'b1; bus_r.num_adds = 16'd2; bus_r.dest_addr = 16'h1234;
    @(posedge clk); #1 bus_r.start = 1'b0;
    await_done(to, dc);
    e = sb_q.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout: done not seen within budget"); end
    vectors++; if (fe_count !== 5)      begin miscompares++; $display("FAIL stall_fetch_cnt: got %0d want 5", fe_count); end
    vectors++; if (wr_r_s !== e.data_r) begin miscompares++; $display("FAIL stall_data_relu: got %h want %h", wr_r_s, e.data_r); end
    vectors++; if (wr_l_s !== e.data_l) begin miscompares++; $display("FAIL stall_data_lin: got %h want %h", wr_l_s, e.data_l); end
    vectors++; if (wr_addr_s !== e.addr) begin miscompares++; $display("FAIL stall_addr: got %h want %h", wr_addr_s, e.addr); end
    repeat (6) @(negedge clk);
    vectors++; if (wr_count !== 1)      begin miscompares++; $display("FAIL stall_wr_count: got %0d want 1", wr_count); end
    vectors++; if (bus_r.busy !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got %b want 0", bus_r.busy); end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit to; int dc; int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 8);
      fill(n, 2);
      launch(n, 16'(16'h0300 + k));
      await_done(to, dc);
      e = sb_q.pop_front();
      vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: run %0d done not seen", k); end
      vectors++; if (wr_r_s !== e.data_r || wr_l_s !== e.data_l) begin miscompares++; $display("FAIL b2b_data: run %0d got %h/%h want %h/%h", k, wr_r_s, wr_l_s, e.data_r, e.data_l); end
      vectors++; if (wr_addr_s !== e.addr || fe_count !== n) begin miscompares++; $display("FAIL b2b_addr_fetch: run %0d got %h/%0d want %h/%0d", k, wr_addr_s, fe_count, e.addr, n); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit to; int dc;
    model_on = 1'b0;
    @(posedge clk); #1;
    wr_count = 0; bus_r.in_we = 1'b0;
    bus_r.start = 1'b1; bus_r.num_adds = 16'd4; bus_r.dest_addr = 16'h0055;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      bus_r.start  = 1'b0;
      bus_r.in_we  = (k == 2 || k == 3);
      bus_r.in_val = 16'h0100; bus_r.in_wt = 16'h0100;
    end
    vectors++; if (bus_r.busy !== 1'b1 || bus_r.fetch_en !== 1'b0) begin miscompares++; $display("FAIL mid_in_drain: got busy %b fetch_en %b want 1 0", bus_r.busy, bus_r.fetch_en); end
    rst = 1'b1;
    #1;
    vectors++; if (bus_r.busy !== 1'b0 || bus_r.fetch_en !== 1'b0 || bus_r.wr_en !== 1'b0 || bus_r.done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ctrl: got busy %b fe %b we %b done %b want all 0", bus_r.busy, bus_r.fetch_en, bus_r.wr_en, bus_r.done); end
    vectors++; if (bus_r.wr_data !== 16'h0 || bus_r.wr_addr !== 16'h0) begin miscompares++; $display("FAIL mid_rst_port: got %h@%h want 0000@0000", bus_r.wr_data, bus_r.wr_addr); end
    @(posedge clk); #1 rst = 1'b0; bus_r.in_we = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus_r.in_we = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (wr_count !== 0 || bus_r.busy !== 1'b0) begin miscompares++; $display("FAIL mid_late_we: got wr_count %0d busy %b want 0 0", wr_count, bus_r.busy); end
    model_on = 1'b1;
    fill(2, 1);
    launch(2, 16'h0077);
    await_done(to, dc);
    e = sb_q.pop_front();
    vectors++; if (to) begin miscompares++; $display("FAIL mid_restart_timeout: done not seen within budget"); end
    vectors++; if (wr_l_s !== e.data_l || wr_addr_s !== e.addr) begin miscompares++; $display("FAIL mid_restart: got %h@%h want %h@%h", wr_l_s, wr_addr_s, e.data_l, e.addr); end
  endtask

  initial begin
    rst = 1'b1;
    model_on = 1'b1;
    pending = 0; dlv_idx = 0; wait_ctr = 0; fe_count = 0;
    wr_count = 0; wr_cyc = 0; start_cyc = 0;
    wr_addr_s = '0; wr_r_s = '0; wr_l_s = '0;
    bus_r.start = 1'b0; bus_r.num_adds = '0; bus_r.dest_addr = '0;
    bus_r.in_val = '0; bus_r.in_wt = '0; bus_r.in_we = 1'b0;
    fill(0, 0);
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_zero_terms();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
